// File: rtl/stereo_disparity_engine_if.sv
// Frame-buffer read ports and disparity result write port of stereo_disparity_engine.
// Cost field width follows STEREO_SAD_EN (absolute-difference cost) when defined.
interface stereo_disparity_engine_if #(
  parameter int IMG_W      = 240,
  parameter int IMG_H      = 320,
  parameter int BLOCK_SIZE = 6,
  parameter int MAX_DISP   = 64,
  parameter int PIX_W      = 8
);
  localparam longint PMAX = (longint'(1) << PIX_W) - 1;
  localparam int AW = $clog2(IMG_W*IMG_H);
  localparam int DW = $clog2(MAX_DISP+1);
`ifdef STEREO_SAD_EN
  localparam int CW = $clog2(longint'(BLOCK_SIZE*BLOCK_SIZE)*PMAX + 1);
`else
  localparam int CW = $clog2(longint'(BLOCK_SIZE*BLOCK_SIZE)*PMAX*PMAX + 1);
`endif

  logic [AW-1:0]    left_addr_out;
  logic [PIX_W-1:0] left_data_in;
  logic [AW-1:0]    right_addr_out;
  logic [PIX_W-1:0] right_data_in;
  logic             disp_we_out;
  logic [AW-1:0]    disp_addr_out;
  logic [DW-1:0]    disp_data_out;
  logic [CW-1:0]    cost_out;

  modport master (
    output left_addr_out, right_addr_out, disp_we_out, disp_addr_out, disp_data_out, cost_out,
    input  left_data_in, right_data_in
  );
  modport slave (
    input  left_addr_out, right_addr_out, disp_we_out, disp_addr_out, disp_data_out, cost_out,
    output left_data_in, right_data_in
  );
endinterface

// File: rtl/stereo_disparity_engine.sv
// Block-matching disparity engine: per anchor, load the left window, sweep d, keep lowest cost.
// Define STEREO_SAD_EN for an absolute-difference cost instead of squared difference.
module stereo_disparity_engine #(
  parameter int IMG_W      = 240,
  parameter int IMG_H      = 320,
  parameter int BLOCK_SIZE = 6,
  parameter int MAX_DISP   = 64,
  parameter int PIX_W      = 8,
  parameter int RD_LAT     = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic start_in,
  output logic busy_out,
  output logic done_out,
  stereo_disparity_engine_if.master bus
);
  localparam int B    = BLOCK_SIZE;
  localparam int BB   = B*B;
  localparam int SLEN = BB + RD_LAT;
  localparam longint PMAX = (longint'(1) << PIX_W) - 1;
  localparam int AW = $clog2(IMG_W*IMG_H);
  localparam int DW = $clog2(MAX_DISP+1);
`ifdef STEREO_SAD_EN
  localparam int CW = $clog2(longint'(BB)*PMAX + 1);
`else
  localparam int CW = $clog2(longint'(BB)*PMAX*PMAX + 1);
`endif
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int KW = $clog2(B+1);
  localparam int NW = $clog2(SLEN+1);
  localparam int IW = $clog2(BB);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_L, S_ACCUM, S_COMPARE, S_WRITE, S_DONE} state_t;

  state_t                     state, n_state;
  logic [NW-1:0]              cnt, n_cnt;
  logic [XW-1:0]              x, n_x;
  logic [YW-1:0]              y, n_y;
  logic [DW-1:0]              d, n_d, dmax, best_d, w_d;
  logic [KW-1:0]              kx, ky, n_kx, n_ky;
  logic                       n_issue, last_anchor, better;
  logic [RD_LAT:0]            vld_pipe;
  logic [CW-1:0]              acc, best_cost, w_cost, term;
  logic [BB-1:0][PIX_W-1:0]   lwin;
  logic [IW-1:0]              rd_idx;
  logic [PIX_W-1:0]           lpix, adiff;
  logic [31:0]                row_addr;

  assign dmax        = (32'(x) < MAX_DISP) ? DW'(x) : DW'(MAX_DISP);
  assign last_anchor = (32'(x) == IMG_W-B) && (32'(y) == IMG_H-B);

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= n_state;
  end

  always_comb begin
    n_state = state;
    n_x     = x;
    n_y     = y;
    n_d     = d;
    unique case (state)
      S_IDLE:    if (start_in) begin n_state = S_LOAD_L; n_x = '0; n_y = '0; end
      S_LOAD_L:  if (32'(cnt) == SLEN-1) begin n_state = S_ACCUM; n_d = '0; end
      S_ACCUM:   if (32'(cnt) == SLEN-1) n_state = S_COMPARE;
      S_COMPARE: if (d < dmax) begin n_state = S_ACCUM; n_d = d + 1'b1; end
                 else n_state = S_WRITE;
      S_WRITE: begin
        if (last_anchor) n_state = S_DONE;
        else begin
          n_state = S_LOAD_L;
          if (32'(x) == IMG_W-B) begin n_x = '0; n_y = y + 1'b1; end
          else n_x = x + 1'b1;
        end
      end
      S_DONE:    n_state = S_IDLE;
      default:   n_state = S_IDLE;
    endcase
  end

  // Addresses are registered one cycle ahead so read k is on the bus in phase cycle k
  // and its data lands in cycle k+RD_LAT, still inside the same phase.
  always_comb begin
    n_cnt   = '0;
    n_kx    = kx;
    n_ky    = ky;
    n_issue = 1'b0;
    if (n_state == S_LOAD_L || n_state == S_ACCUM) begin
      if (n_state == state) n_cnt = cnt + 1'b1;
      n_issue = (32'(n_cnt) < BB);
      if (n_cnt == '0) begin
        n_kx = '0;
        n_ky = '0;
      end else if (n_issue) begin
        if (32'(kx) == B-1) begin n_kx = '0; n_ky = ky + 1'b1; end
        else n_kx = kx + 1'b1;
      end
    end
  end

  assign row_addr = (32'(n_y) + 32'(n_ky)) * IMG_W + 32'(n_x) + 32'(n_kx);

  assign rd_idx = IW'(cnt - NW'(RD_LAT));
  assign lpix   = lwin[rd_idx];
  assign adiff  = (lpix >= bus.right_data_in) ? lpix - bus.right_data_in
                                              : bus.right_data_in - lpix;
`ifdef STEREO_SAD_EN
  assign term = CW'(adiff);
`else
  logic [2*PIX_W-1:0] sq;
  assign sq   = adiff * adiff;
  assign term = CW'(sq);
`endif

  // Strictly-lower replaces; ascending d means ties keep the smallest disparity.
  assign better = (acc < best_cost);
  assign w_cost = better ? acc : best_cost;
  assign w_d    = better ? d   : best_d;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt                <= '0;
      x                  <= '0;
      y                  <= '0;
      d                  <= '0;
      kx                 <= '0;
      ky                 <= '0;
      vld_pipe           <= '0;
      acc                <= '0;
      best_cost          <= '0;
      best_d             <= '0;
      lwin               <= '0;
      busy_out           <= 1'b0;
      done_out           <= 1'b0;
      bus.left_addr_out  <= '0;
      bus.right_addr_out <= '0;
      bus.disp_we_out    <= 1'b0;
      bus.disp_addr_out  <= '0;
      bus.disp_data_out  <= '0;
      bus.cost_out       <= '0;
    end else begin
      cnt      <= n_cnt;
      x        <= n_x;
      y        <= n_y;
      d        <= n_d;
      kx       <= n_kx;
      ky       <= n_ky;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], n_issue};
      if (n_issue && n_state == S_LOAD_L) bus.left_addr_out  <= AW'(row_addr);
      if (n_issue && n_state == S_ACCUM)  bus.right_addr_out <= AW'(row_addr - 32'(n_d));

      if (vld_pipe[RD_LAT] && state == S_LOAD_L) lwin[rd_idx] <= bus.left_data_in;

      if (state != S_ACCUM && n_state == S_ACCUM)      acc <= '0;
      else if (vld_pipe[RD_LAT] && state == S_ACCUM)  acc <= acc + term;

      if (state != S_LOAD_L && n_state == S_LOAD_L) begin
        best_cost <= '1;
        best_d    <= '0;
      end else if (state == S_COMPARE) begin
        best_cost <= w_cost;
        best_d    <= w_d;
      end

      busy_out        <= (n_state != S_IDLE) && (n_state != S_DONE);
      done_out        <= (n_state == S_DONE);
      bus.disp_we_out <= (n_state == S_WRITE);
      if (n_state == S_WRITE) begin
        bus.disp_addr_out <= AW'(32'(y) * IMG_W + 32'(x));
        bus.disp_data_out <= w_d;
        bus.cost_out      <= w_cost;
      end
    end
  end
endmodule

// File: tb/tb_stereo_disparity_engine.sv
// Scoreboard bench for stereo_disparity_engine: a reference model fills the expected-write
// queue per frame, a negedge monitor pops and compares every result write.
`timescale 1ns/1ps
module tb_stereo_disparity_engine;
  localparam int IMG_W = 16, IMG_H = 8, B = 3, MAX_DISP = 4, PIX_W = 8, RD_LAT = 2;
  localparam int NPIX  = IMG_W*IMG_H;
  localparam int SLEN  = B*B + RD_LAT;
  localparam int NANCH = (IMG_W-B+1)*(IMG_H-B+1);
  localparam longint PMAX = (longint'(1) << PIX_W) - 1;
`ifdef STEREO_SAD_EN
  localparam int CW = $clog2(longint'(B*B)*PMAX + 1);
`else
  localparam int CW = $clog2(longint'(B*B)*PMAX*PMAX + 1);
`endif

  typedef struct {
    int     addr;
    int     disp;
    longint cost;
    int     cyc;
  } exp_t;

  logic clk_100mhz = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  always #5 clk_100mhz = ~clk_100mhz;

  stereo_disparity_engine_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BLOCK_SIZE(B),
    .MAX_DISP(MAX_DISP), .PIX_W(PIX_W)) bus();

  stereo_disparity_engine #(.IMG_W(IMG_W), .IMG_H(IMG_H), .BLOCK_SIZE(B),
    .MAX_DISP(MAX_DISP), .PIX_W(PIX_W), .RD_LAT(RD_LAT)) dut (
    .clk_in   (clk_100mhz),
    .rst_in   (rst_n),
    .start_in (start),
    .busy_out (busy),
    .done_out (done),
    .bus      (bus)
  );

  // Two-stage frame buffers: data for the address on the bus appears two cycles later.
  logic [PIX_W-1:0] lmem [NPIX];
  logic [PIX_W-1:0] rmem [NPIX];
  logic [PIX_W-1:0] l_d1, r_d1;
  always @(posedge clk_100mhz) begin
    l_d1              <= lmem[bus.left_addr_out];
    bus.left_data_in  <= l_d1;
    r_d1              <= rmem[bus.right_addr_out];
    bus.right_data_in <= r_d1;
  end

  exp_t sb[$];
  int errors = 0, checks = 0;
  int wr_cnt = 0, done_cnt = 0, frame_cyc = 0;
  int mon_cyc = 0, mon_last = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: exhaustive search per anchor straight from the matching rules.
  task automatic build_expect(output int total);
    exp_t e;
    total = 0;
    for (int y = 0; y <= IMG_H-B; y++)
      for (int x = 0; x <= IMG_W-B; x++) begin
        int dm;
        longint best;
        int bd;
        dm   = (x < MAX_DISP) ? x : MAX_DISP;
        best = (longint'(1) << CW) - 1;
        bd   = 0;
        for (int d = 0; d <= dm; d++) begin
          longint c;
          c = 0;
          for (int j = 0; j < B; j++)
            for (int i = 0; i < B; i++) begin
              int df;
              df = int'(lmem[(y+j)*IMG_W + x+i]) - int'(rmem[(y+j)*IMG_W + x+i-d]);
`ifdef STEREO_SAD_EN
              c += (df < 0) ? -df : df;
`else
              c += df*df;
`endif
            end
          if (c < best) begin best = c; bd = d; end
        end
        e.addr = y*IMG_W + x;
        e.disp = bd;
        e.cost = best;
        e.cyc  = SLEN + (dm+1)*(SLEN+1) + 1;
        total += e.cyc;
        sb.push_back(e);
      end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_100mhz);
      if (busy) mon_cyc++;
      else begin mon_cyc = 0; mon_last = 0; end
      if (bus.disp_we_out) begin
        wr_cnt++;
        if (sb.size() == 0) chk("unexpected_write_addr", bus.disp_addr_out, -1);
        else begin
          e = sb.pop_front();
          chk("wr_addr", bus.disp_addr_out, e.addr);
          chk("wr_disp", bus.disp_data_out, e.disp);
          chk("wr_cost", bus.cost_out, e.cost);
          chk("anchor_cycles", mon_cyc - mon_last, e.cyc);
        end
        mon_last  = mon_cyc;
        frame_cyc = mon_cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_write", prev_we, 1);
        chk("busy_low_in_done", busy, 0);
      end
      prev_we = bus.disp_we_out;
    end
  end

  task automatic pulse_start();
    @(negedge clk_100mhz); start = 1'b1;
    @(negedge clk_100mhz); start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run_frame(input bit perturb);
    int total, wr0, dn0, n;
    bit seen;
    build_expect(total);
    wr0 = wr_cnt; dn0 = done_cnt;
    pulse_start();
    n = 0; seen = 0;
    while (n < 20000) begin
      @(negedge clk_100mhz);
      n++;
      if (done) begin seen = 1; break; end
      start = perturb && (n % 997 == 500);
    end
    start = 1'b0;
    chk("frame_done_seen", seen, 1);
    repeat (20) @(negedge clk_100mhz);
    chk("done_pulses", done_cnt - dn0, 1);
    chk("writes_in_frame", wr_cnt - wr0, NANCH);
    chk("sb_drained", sb.size(), 0);
    chk("busy_after_done", busy, 0);
    chk("frame_cycles", frame_cyc, total);
    sb.delete();
  endtask

  initial begin : main
    int total, wr0, dn0, n;
    repeat (3) @(negedge clk_100mhz);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", bus.disp_we_out, 0);
    chk("rst_disp_addr", bus.disp_addr_out, 0);
    chk("rst_disp_data", bus.disp_data_out, 0);
    chk("rst_cost", bus.cost_out, 0);
    chk("rst_left_addr", bus.left_addr_out, 0);
    chk("rst_right_addr", bus.right_addr_out, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NPIX; i++) begin lmem[i] = 8'h80; rmem[i] = 8'h80; end
    run_frame(0);

    for (int i = 0; i < NPIX; i++) lmem[i] = PIX_W'($urandom);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        rmem[y*IMG_W+x] = (x+2 < IMG_W) ? lmem[y*IMG_W+x+2] : PIX_W'($urandom);
    run_frame(0);
    run_frame(1);

    for (int i = 0; i < NPIX; i++) begin lmem[i] = '1; rmem[i] = '0; end
    run_frame(0);

    for (int i = 0; i < NPIX; i++) begin lmem[i] = PIX_W'($urandom); rmem[i] = PIX_W'($urandom); end
    build_expect(total);
    wr0 = wr_cnt; dn0 = done_cnt;
    pulse_start();
    n = 0;
    while (wr_cnt - wr0 < 33 && n < 20000) begin @(negedge clk_100mhz); n++; end
    chk("reached_anchor_4_2", wr_cnt - wr0, 33);
    repeat (13) @(negedge clk_100mhz);
    sb.delete();
    rst_n = 1'b0;
    @(negedge clk_100mhz);
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_we", bus.disp_we_out, 0);
    repeat (300) @(negedge clk_100mhz);
    chk("abort_no_writes", wr_cnt - wr0, 33);
    chk("abort_no_done", done_cnt - dn0, 0);
    chk("abort_busy_idle", busy, 0);
    run_frame(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
